alu_muldiv: RTL and testbench

- Parametrised multi-cycle integer multiply/divide unit that sits beside the single-cycle datapath ALU in the EX stage.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO against internal HI/LO registers.
- MFHI/MFLO are plain reads of o_hi/o_lo.
- The pipeline stalls on o_busy and resumes on o_done.

---
 rtl/alu_muldiv.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle integer multiply/divide unit with internal HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle. A single FIX cycle applies the sign correction and commits HI/LO.
// MTHI/MTLO write HI/LO directly from IDLE. MFHI/MFLO read o_hi/o_lo.
// Optional feature macro: ALU_MULDIV_DIV0_EN. When it is defined, the unit
// reports divide-by-zero on o_div0 and finishes the operation in a single
// cycle without changing HI/LO.
module alu_muldiv #(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    output logic              o_busy,
    output logic              o_done,
`ifdef ALU_MULDIV_DIV0_EN
    output logic              o_div0,
`endif
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WB
    } state_e;

    // Control state. It is reset.
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
`ifdef ALU_MULDIV_DIV0_EN
    logic                div0_q, div0_d;
`endif

    // Datapath working state. It is loaded on accept and needs no reset.
    logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;   // multiplier / dividend->quotient
    logic [DATA_W-1:0]   opnd_q, opnd_d;       // |multiplicand| or |divisor|
    logic [DATA_W-1:0]   a_raw_q, a_raw_d;     // A as issued, for divide by zero
    logic                neg_res_q, neg_res_d; // negate product / quotient
    logic                neg_rem_q, neg_rem_d; // negate remainder
    logic                is_div_q, is_div_d;
    logic                b_zero_q, b_zero_d;

    // Operand preparation for an accept in this cycle.
    logic                op_signed;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b;

    // Per-iteration arithmetic.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] prod_raw, prod_fix;

    // Operand magnitudes and sign flags for the request on the inputs.
    always_comb begin
        op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
        sign_a    = op_signed & i_A[DATA_W-1];
        sign_b    = op_signed & i_B[DATA_W-1];
        mag_a     = sign_a ? -i_A : i_A;
        mag_b     = sign_b ? -i_B : i_B;
    end

    // One shift-add step, one restoring-division step, and the signed product fixup.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_diff = {1'b0, acc_hi_q, acc_lo_q[DATA_W-1]} - {2'b00, opnd_q};
        prod_raw = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res_q ? -prod_raw : prod_raw;
    end

    // Next-state logic: request decode, iteration control, and the fixup/commit step.
    // NOTE: every signal this block writes gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef ALU_MULDIV_DIV0_EN
        div0_d    = 1'b0;
`endif
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        b_zero_d  = b_zero_q;

        unique case (state_q)
            // WB is the done cycle. A new request is accepted here as in IDLE.
            S_IDLE, S_WB: begin
                state_d = S_IDLE;
                if (i_start) begin
                    unique case (i_op)
                        OP_MULT, OP_MULTU: begin
                            acc_hi_d  = '0;
                            acc_lo_d  = mag_b;
                            opnd_d    = mag_a;
                            a_raw_d   = i_A;
                            neg_res_d = sign_a ^ sign_b;
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            b_zero_d  = 1'b0;
                            cnt_d     = CNT_W'(DATA_W);
                            state_d   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef ALU_MULDIV_DIV0_EN
                            if (i_B == '0) begin
                                done_d = 1'b1;
                                div0_d = 1'b1;
                            end else begin
`else
                            begin
`endif
                                acc_hi_d  = '0;
                                acc_lo_d  = mag_a;
                                opnd_d    = mag_b;
                                a_raw_d   = i_A;
                                neg_res_d = sign_a ^ sign_b;
                                neg_rem_d = sign_a;
                                is_div_d  = 1'b1;
                                b_zero_d  = (i_B == '0);
                                cnt_d     = CNT_W'(DATA_W);
                                state_d   = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = i_A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = i_A;
                            done_d = 1'b1;
                        end
                        default: ; // reserved opcodes are ignored
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_d = mul_sum[DATA_W:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_diff[DATA_W+1]) begin
                    acc_hi_d = div_diff[DATA_W-1:0];
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_hi_d = {acc_hi_q[DATA_W-2:0], acc_lo_q[DATA_W-1]};
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                end
                done_d  = 1'b1;
                state_d = S_WB;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous active-high reset. Reset discards any in-flight operation.
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_DIV0_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef ALU_MULDIV_DIV0_EN
            div0_q  <= div0_d;
`endif
        end
    end

    // Datapath registers. They are reloaded on every accept.
    // NOTE: these registers are deliberately not reset. Nothing reads them
    // until an accept has loaded them, and without a reset they need no reset fan-out.
    always_ff @(posedge i_clk) begin
        acc_hi_q  <= acc_hi_d;
        acc_lo_q  <= acc_lo_d;
        opnd_q    <= opnd_d;
        a_raw_q   <= a_raw_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        is_div_q  <= is_div_d;
        b_zero_q  <= b_zero_d;
    end

    assign o_busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
`ifdef ALU_MULDIV_DIV0_EN
    assign o_div0 = div0_q;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv (DATA_W=32).
// Expected values are hand-computed constants. Define ALU_MULDIV_DIV0_EN
// to exercise the single-cycle divide-by-zero variant.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [2:0]   i_op;
    logic [W-1:0] i_A;
    logic [W-1:0] i_B;
    logic         o_busy;
    logic         o_done;
`ifdef ALU_MULDIV_DIV0_EN
    logic         o_div0;
`endif
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    int total = 0;
    int bad   = 0;
    int lat;
    int bcnt;
    logic [W-1:0] hi_prev;
    logic [W-1:0] lo_prev;

    alu_muldiv #(.DATA_W(W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_op    (i_op),
        .i_A     (i_A),
        .i_B     (i_B),
        .o_busy  (o_busy),
        .o_done  (o_done),
`ifdef ALU_MULDIV_DIV0_EN
        .o_div0  (o_div0),
`endif
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Holds the request for one rising edge, then
    // scrambles the inputs so that a unit that fails to latch them is caught.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_A     = a;
        i_B     = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op    = 3'b111;
        i_A     = ~a;
        i_B     = ~b;
    endtask

    // Counts negedges after the accept until o_done, bounded to 100 cycles.
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < 100) begin
            @(negedge i_clk);
            n++;
            if (o_busy) busy_n++;
            if (o_done) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_op    = 3'b000;
        i_A     = '0;
        i_B     = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_hi", o_hi, 0);
        check("reset_lo", o_lo, 0);

        // MULTU max*max, with latency and busy-window checks
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("multu_max_latency", lat, 34);
        check("multu_max_busy_cycles", bcnt, 33);
        check("multu_max_hi", o_hi, 32'hFFFF_FFFE);
        check("multu_max_lo", o_lo, 32'h0000_0001);
        @(negedge i_clk);
        check("done_single_pulse", o_done, 0);
        check("busy_after_done", o_busy, 0);

        // MULT -3 * 7 = -21
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bcnt);
        check("mult_neg_latency", lat, 34);
        check("mult_neg_hi", o_hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", o_lo, 32'hFFFF_FFEB);

        // DIVU 100 / 7, then DIV 9 / -2 accepted in its done cycle
        @(negedge i_clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        check("divu_latency", lat, 34);
        check("divu_lo", o_lo, 32'd14);
        check("divu_hi", o_hi, 32'd2);
        issue(OP_DIV, 32'd9, 32'hFFFF_FFFE);
        wait_done(lat, bcnt);
        check("b2b_latency", lat, 34);
        check("b2b_lo", o_lo, 32'hFFFF_FFFC);
        check("b2b_hi", o_hi, 32'd1);

        // DIV -7 / 2, then the signed overflow case
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        check("div_neg_lo", o_lo, 32'hFFFF_FFFD);
        check("div_neg_hi", o_hi, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("div_ovf_latency", lat, 34);
        check("div_ovf_lo", o_lo, 32'h8000_0000);
        check("div_ovf_hi", o_hi, 32'h0000_0000);

        // MTHI: single-cycle move, no busy
        lo_prev = o_lo;
        issue(OP_MTHI, 32'hCAFE_F00D, 32'd0);
        wait_done(lat, bcnt);
        check("mthi_latency", lat, 1);
        check("mthi_busy_cycles", bcnt, 0);
        check("mthi_hi", o_hi, 32'hCAFE_F00D);
        check("mthi_lo_kept", o_lo, lo_prev);

        // Reserved opcode: no done, no busy, HI/LO untouched
        @(negedge i_clk);
        hi_prev = o_hi;
        lo_prev = o_lo;
        issue(3'b110, 32'h1111_1111, 32'h2222_2222);
        bcnt = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_done || o_busy) bcnt++;
        end
        check("reserved_no_activity", bcnt, 0);
        check("reserved_hi", o_hi, hi_prev);
        check("reserved_lo", o_lo, lo_prev);

        // MULTU 5*5 with a DIVU request while busy: request ignored, HI/LO held
        hi_prev = o_hi;
        lo_prev = o_lo;
        issue(OP_MULTU, 32'd5, 32'd5);
        repeat (9) @(negedge i_clk);
        check("hold_busy", o_busy, 1);
        check("hold_hi", o_hi, hi_prev);
        check("hold_lo", o_lo, lo_prev);
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(lat, bcnt);
        check("ignore_latency", lat, 25);
        check("ignore_lo", o_lo, 32'd25);
        check("ignore_hi", o_hi, 32'd0);

        // Reset in the middle of a MULT discards it and clears HI/LO
        @(negedge i_clk);
        issue(OP_MULT, 32'd3, 32'd4);
        repeat (4) @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("midreset_hi", o_hi, 0);
        check("midreset_lo", o_lo, 0);
        check("midreset_busy", o_busy, 0);
        check("midreset_done", o_done, 0);
        bcnt = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done || o_busy) bcnt++;
        end
        check("midreset_op_discarded", bcnt, 0);
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        wait_done(lat, bcnt);
        check("mtlo_latency", lat, 1);
        check("mtlo_busy_cycles", bcnt, 0);
        check("mtlo_lo", o_lo, 32'h0000_1234);
        check("mtlo_hi_kept", o_hi, 0);

        // Divide by zero
        @(negedge i_clk);
`ifdef ALU_MULDIV_DIV0_EN
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, bcnt);
        check("div0_latency", lat, 1);
        check("div0_busy_cycles", bcnt, 0);
        check("div0_flag", o_div0, 1);
        check("div0_hi_kept", o_hi, 0);
        check("div0_lo_kept", o_lo, 32'h0000_1234);
        @(negedge i_clk);
        check("div0_flag_pulse", o_div0, 0);
        check("div0_done_pulse", o_done, 0);
`else
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, bcnt);
        check("divu0_latency", lat, 34);
        check("divu0_lo", o_lo, 32'hFFFF_FFFF);
        check("divu0_hi", o_hi, 32'd5);
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done(lat, bcnt);
        check("div0_signed_latency", lat, 34);
        check("div0_signed_lo", o_lo, 32'hFFFF_FFFF);
        check("div0_signed_hi", o_hi, 32'hFFFF_FFFB);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
